// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one fixed-latency memory port between two requesters.
// Optional ARB_ADDR_CHECK_EN: addresses >= MEM_DEPTH complete with err instead of reaching memory.
module mem_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 12,
  parameter int MEM_LAT   = 1,
  parameter int MEM_DEPTH = 4096
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  input  logic [DATA_W/8-1:0] m0_wstrb,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  output logic                m0_err,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  input  logic [DATA_W/8-1:0] m1_wstrb,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                m1_err,
  output logic                mem_en,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic [DATA_W-1:0]   mem_rdata
);
  typedef enum logic {IDLE, WAIT} state_t;
  state_t state, state_nx;
  logic [2:0] cnt, cnt_nx;
  logic owner, owner_nx, last_gnt, last_gnt_nx, err_q, err_nx;
  logic pick, go, bad, done;
  logic [ADDR_W-1:0] sel_addr;
  // pick: 0 = m0, 1 = m1; on contention the side not granted last wins
  assign pick     = (m0_req & m1_req) ? ~last_gnt : m1_req;
  assign sel_addr = pick ? m1_addr : m0_addr;
  assign go       = ~reset & (state == IDLE) & (m0_req | m1_req);
  assign done     = ~reset & (state == WAIT) & (cnt == 3'd1);
`ifdef ARB_ADDR_CHECK_EN
  assign bad = 32'(sel_addr) >= MEM_DEPTH;
`else
  localparam int unused_depth = MEM_DEPTH;
  assign bad = 1'b0;
`endif
  always_comb begin
    state_nx    = state;
    cnt_nx      = cnt;
    owner_nx    = owner;
    last_gnt_nx = last_gnt;
    err_nx      = err_q;
    if (go) begin
      state_nx    = WAIT;
      cnt_nx      = bad ? 3'd1 : 3'(MEM_LAT);
      owner_nx    = pick;
      last_gnt_nx = pick;
      err_nx      = bad;
    end else if (state == WAIT) begin
      cnt_nx   = cnt - 3'd1;
      state_nx = (cnt == 3'd1) ? IDLE : WAIT;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      owner    <= 1'b0;
      last_gnt <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      owner    <= owner_nx;
      last_gnt <= last_gnt_nx;
      err_q    <= err_nx;
    end
  end
  assign m0_gnt    = go & ~pick;
  assign m1_gnt    = go & pick;
  assign mem_en    = go & ~bad;
  assign mem_we    = mem_en & (pick ? m1_we : m0_we);
  assign mem_addr  = mem_en ? sel_addr : '0;
  assign mem_wdata = mem_en ? (pick ? m1_wdata : m0_wdata) : '0;
  assign mem_wstrb = mem_en ? (pick ? m1_wstrb : m0_wstrb) : '0;
  assign m0_rvalid = done & ~owner;
  assign m1_rvalid = done & owner;
  assign m0_err    = m0_rvalid & err_q;
  assign m1_err    = m1_rvalid & err_q;
  assign m0_rdata  = (m0_rvalid & ~err_q) ? mem_rdata : '0;
  assign m1_rdata  = (m1_rvalid & ~err_q) ? mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed checks of mem_arbiter on three instances with MEM_LAT = 1, 2, 3.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [11:0] m0_addr = '0, m1_addr = '0;
  logic [31:0] m0_wdata = '0, m1_wdata = '0, mem_rdata = '0;
  logic [3:0] m0_wstrb = '0, m1_wstrb = '0;
  logic [3:1] m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_en, mem_we;
  logic [31:0] m0_rdata [1:3];
  logic [31:0] m1_rdata [1:3];
  logic [31:0] mem_wdata [1:3];
  logic [11:0] mem_addr [1:3];
  logic [3:0] mem_wstrb [1:3];
  int nvec = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  for (genvar g = 1; g <= 3; g++) begin : gen_dut
    mem_arbiter #(.DATA_W(32), .ADDR_W(12), .MEM_LAT(g), .MEM_DEPTH(2048)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_gnt(m0_gnt[g]), .m0_rvalid(m0_rvalid[g]), .m0_rdata(m0_rdata[g]), .m0_err(m0_err[g]),
      .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_gnt(m1_gnt[g]), .m1_rvalid(m1_rvalid[g]), .m1_rdata(m1_rdata[g]), .m1_err(m1_err[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_wstrb(mem_wstrb[g]), .mem_rdata(mem_rdata)
    );
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    step();
    reset = 1'b1;
    m0_req = 1'b0;
    m1_req = 1'b0;
    step();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      @(negedge clk);
      nvec++;
      if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_en} !== 21'd0) begin
        nerr++;
        $display("FAIL reset_outputs cycle %0d: got %b expected 0", i,
                 {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_en});
      end
    end
    step();
    reset = 1'b0;
    @(negedge clk);
    nvec++;
    if ({m0_gnt, m1_gnt} !== 6'b111_000) begin
      nerr++;
      $display("FAIL reset_first_grant: got m0_gnt=%b m1_gnt=%b expected 111 000", m0_gnt, m1_gnt);
    end
    do_reset();
  endtask
  task automatic test_read();
    step();
    m0_req = 1'b1;
    m0_we = 1'b0;
    m0_addr = 12'h010;
    mem_rdata = '0;
    @(negedge clk);
    nvec++;
    if ({m0_gnt[2], mem_en[2], mem_we[2], mem_addr[2]} !== {3'b110, 12'h010}) begin
      nerr++;
      $display("FAIL read_grant: got gnt=%b en=%b we=%b addr=%h expected 1 1 0 010",
               m0_gnt[2], mem_en[2], mem_we[2], mem_addr[2]);
    end
    step();
    m0_req = 1'b0;
    @(negedge clk);
    nvec++;
    if ({m0_gnt[2], m0_rvalid[2], mem_en[2], mem_addr[2]} !== 15'd0) begin
      nerr++;
      $display("FAIL read_wait: got gnt=%b rvalid=%b en=%b addr=%h expected all 0",
               m0_gnt[2], m0_rvalid[2], mem_en[2], mem_addr[2]);
    end
    step();
    mem_rdata = 32'hDEADBEEF;
    @(negedge clk);
    nvec++;
    if ({m0_rvalid[2], m0_rdata[2], m1_rvalid[2]} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
      nerr++;
      $display("FAIL read_data: got rvalid=%b rdata=%h m1_rvalid=%b expected 1 deadbeef 0",
               m0_rvalid[2], m0_rdata[2], m1_rvalid[2]);
    end
    step();
    @(negedge clk);
    nvec++;
    if ({m0_rvalid[2], m0_rdata[2]} !== 33'd0) begin
      nerr++;
      $display("FAIL read_after: got rvalid=%b rdata=%h expected 0 0", m0_rvalid[2], m0_rdata[2]);
    end
    do_reset();
  endtask
  task automatic test_round_robin();
    logic [3:0] exp_v [0:5];
    logic [31:0] exp_d;
    exp_v = '{4'b1000, 4'b0010, 4'b0100, 4'b0001, 4'b1000, 4'b0010};
    for (int k = 0; k < 6; k++) begin
      step();
      if (k == 0) begin
        m0_req = 1'b1;
        m1_req = 1'b1;
        m0_addr = 12'h100;
        m1_addr = 12'h200;
      end
      mem_rdata = 32'h5A5A_0000 | 32'(k);
      exp_d = (k == 1 || k == 5) ? (32'h5A5A_0000 | 32'(k)) : 32'd0;
      @(negedge clk);
      nvec++;
      if ({m0_gnt[1], m1_gnt[1], m0_rvalid[1], m1_rvalid[1]} !== exp_v[k] || m0_rdata[1] !== exp_d) begin
        nerr++;
        $display("FAIL round_robin cycle %0d: got gnt0/gnt1/rv0/rv1=%b rdata0=%h expected %b %h", k,
                 {m0_gnt[1], m1_gnt[1], m0_rvalid[1], m1_rvalid[1]}, m0_rdata[1], exp_v[k], exp_d);
      end
    end
    do_reset();
  endtask
  task automatic test_write();
    step();
    m1_req = 1'b1;
    m1_we = 1'b1;
    m1_addr = 12'h0A0;
    m1_wdata = 32'h12345678;
    m1_wstrb = 4'b0011;
    @(negedge clk);
    nvec++;
    if ({m0_gnt[2], m1_gnt[2], mem_en[2], mem_we[2], mem_addr[2], mem_wdata[2], mem_wstrb[2]} !==
        {4'b0111, 12'h0A0, 32'h12345678, 4'b0011}) begin
      nerr++;
      $display("FAIL write_issue: got gnt0=%b gnt1=%b en=%b we=%b addr=%h wdata=%h wstrb=%b expected 0 1 1 1 0a0 12345678 0011",
               m0_gnt[2], m1_gnt[2], mem_en[2], mem_we[2], mem_addr[2], mem_wdata[2], mem_wstrb[2]);
    end
    step();
    m1_req = 1'b0;
    m1_we = 1'b0;
    @(negedge clk);
    nvec++;
    if ({mem_en[2], mem_we[2], mem_wdata[2], mem_wstrb[2], m1_rvalid[2]} !== 39'd0) begin
      nerr++;
      $display("FAIL write_idle_bus: got en=%b we=%b wdata=%h wstrb=%b rvalid=%b expected all 0",
               mem_en[2], mem_we[2], mem_wdata[2], mem_wstrb[2], m1_rvalid[2]);
    end
    step();
    @(negedge clk);
    nvec++;
    if ({m1_rvalid[2], m1_err[2], m0_rvalid[2], m0_err[2], m0_rdata[2]} !== {4'b1000, 32'd0}) begin
      nerr++;
      $display("FAIL write_ack: got rv1=%b err1=%b rv0=%b err0=%b rdata0=%h expected 1 0 0 0 0",
               m1_rvalid[2], m1_err[2], m0_rvalid[2], m0_err[2], m0_rdata[2]);
    end
    do_reset();
  endtask
  task automatic test_reset_mid_wait();
    step();
    m0_req = 1'b1;
    m0_addr = 12'h020;
    @(negedge clk);
    nvec++;
    if (m0_gnt[3] !== 1'b1) begin
      nerr++;
      $display("FAIL midreset_grant: got %b expected 1", m0_gnt[3]);
    end
    step();
    m0_req = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    nvec++;
    if ({m0_gnt[3], m1_gnt[3], m0_rvalid[3], m1_rvalid[3], mem_en[3]} !== 5'd0) begin
      nerr++;
      $display("FAIL midreset_during: got %b expected 00000",
               {m0_gnt[3], m1_gnt[3], m0_rvalid[3], m1_rvalid[3], mem_en[3]});
    end
    step();
    reset = 1'b0;
    for (int k = 2; k <= 3; k++) begin
      @(negedge clk);
      nvec++;
      if ({m0_rvalid[3], m1_rvalid[3], mem_en[3]} !== 3'd0) begin
        nerr++;
        $display("FAIL midreset_no_rvalid T+%0d: got rv0=%b rv1=%b en=%b expected 0 0 0", k,
                 m0_rvalid[3], m1_rvalid[3], mem_en[3]);
      end
      step();
    end
    m1_req = 1'b1;
    m1_addr = 12'h030;
    @(negedge clk);
    nvec++;
    if ({m1_gnt[3], mem_en[3], mem_addr[3]} !== {2'b11, 12'h030}) begin
      nerr++;
      $display("FAIL midreset_regrant: got gnt1=%b en=%b addr=%h expected 1 1 030",
               m1_gnt[3], mem_en[3], mem_addr[3]);
    end
    do_reset();
  endtask
  task automatic test_addr_range();
    step();
    m0_req = 1'b1;
    m0_we = 1'b0;
    m0_addr = 12'h900;
    mem_rdata = 32'hCAFEF00D;
`ifdef ARB_ADDR_CHECK_EN
    @(negedge clk);
    nvec++;
    if ({m0_gnt, mem_en, mem_addr[2]} !== {6'b111_000, 12'h000}) begin
      nerr++;
      $display("FAIL addr_err_grant: got gnt=%b en=%b addr=%h expected 111 000 000", m0_gnt, mem_en, mem_addr[2]);
    end
    step();
    m0_req = 1'b0;
    @(negedge clk);
    nvec++;
    if ({m0_rvalid, m0_err, m0_rdata[1], m0_rdata[3]} !== {6'b111_111, 64'd0}) begin
      nerr++;
      $display("FAIL addr_err_resp: got rvalid=%b err=%b rdata1=%h rdata3=%h expected 111 111 0 0",
               m0_rvalid, m0_err, m0_rdata[1], m0_rdata[3]);
    end
    step();
    m1_req = 1'b1;
    m1_addr = 12'h004;
    @(negedge clk);
    nvec++;
    if ({m1_gnt, m0_rvalid} !== 6'b111_000) begin
      nerr++;
      $display("FAIL addr_err_idle: got gnt1=%b rvalid0=%b expected 111 000", m1_gnt, m0_rvalid);
    end
`else
    @(negedge clk);
    nvec++;
    if ({m0_gnt, mem_en, mem_addr[2]} !== {6'b111_111, 12'h900}) begin
      nerr++;
      $display("FAIL addr_pass_grant: got gnt=%b en=%b addr=%h expected 111 111 900", m0_gnt, mem_en, mem_addr[2]);
    end
    step();
    m0_req = 1'b0;
    @(negedge clk);
    nvec++;
    if ({m0_rvalid, m0_err, m0_rdata[1]} !== {6'b001_000, 32'hCAFEF00D}) begin
      nerr++;
      $display("FAIL addr_pass_lat1: got rvalid=%b err=%b rdata1=%h expected 001 000 cafef00d",
               m0_rvalid, m0_err, m0_rdata[1]);
    end
    step();
    @(negedge clk);
    nvec++;
    if ({m0_rvalid, m0_err, m0_rdata[2]} !== {6'b010_000, 32'hCAFEF00D}) begin
      nerr++;
      $display("FAIL addr_pass_lat2: got rvalid=%b err=%b rdata2=%h expected 010 000 cafef00d",
               m0_rvalid, m0_err, m0_rdata[2]);
    end
`endif
    do_reset();
  endtask
  initial begin
    m0_req = 1'b1;
    m1_req = 1'b1;
    test_reset();
    test_read();
    test_round_robin();
    test_write();
    test_reset_mid_wait();
    test_addr_range();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
